imdct_rot_pipe: RTL and testbench

IMDCT_ROT_PIPE -- requirements
Module: imdct_rot_pipe

---
 rtl/imdct_rot_pipe.sv | 191 +++++++++++++++++++
 tb/tb_imdct_rot_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imdct_rot_pipe.sv
// IMDCT pre/post twiddle rotation pipeline.
// A beat enters S1 when in_valid & in_ready. It passes through S1 (pre-shift and
// operand preparation), S2 (three multiplies), S3 (add/sub) and S4 (post-shift
// with saturation), then lands in the output holding register. A single global
// enable stalls every stage while the output beat is held.
module imdct_rot_pipe #(
  parameter int DW   = 32,
  parameter int MSH  = DW,
  parameter int ESW  = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mode,
  input  logic            neg_ai,
  input  logic [ESW-1:0]  es,
  input  logic [DW-1:0]   ar,
  input  logic [DW-1:0]   ai,
  input  logic [DW-1:0]   cps2,
  input  logic [DW-1:0]   sin2a,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   z1,
  output logic [DW-1:0]   z2,
  output logic            sat_z1,
  output logic            sat_z2,
  output logic [CNTW-1:0] sat_cnt,
  input  logic            sat_clr
);

  // Saturation targets: largest/smallest value representable after the post shift.
  localparam logic [DW-1:0] SAT_MAX = {2'b00, {(DW-2){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {2'b11, {(DW-2){1'b0}}};

  // Signed DW x DW multiply, keeping bits [MSH+DW-1:MSH] of the full product.
  function automatic logic [DW-1:0] mul_hi(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] prod;
    prod = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    return DW'(prod >>> MSH);
  endfunction

  // Post-twiddle left shift by min(es, DW-2) with saturation; returns {sat, z}.
  // A value survives the shift only when its top e+2 bits are all sign copies.
  function automatic logic [DW:0] post_shift(input logic [DW-1:0] p, input logic m,
                                             input logic [ESW-1:0] esv);
    logic [31:0]          e;
    logic signed [DW-1:0] hi;
    logic                 fits;
    e = 32'(esv);
    if (e > 32'(DW-2)) e = 32'(DW-2);
    hi   = $signed(p) >>> (32'(DW-2) - e);
    fits = (hi == '0) || (hi == '1);
    if (!m)       return {1'b0, p};
    else if (fits) return {1'b0, p << e};
    else           return {1'b1, (p[DW-1] ? SAT_MIN : SAT_MAX)};
  endfunction

  logic en;
  logic accept;

  // Output register and per-stage valids
  logic            out_valid_q;
  logic [DW-1:0]   z1_q, z2_q;
  logic            sat_z1_q, sat_z2_q;
  logic [CNTW-1:0] sat_cnt_q;
  logic            v1_q, v2_q, v3_q, v4_q;

  // Stage data; mode/es ride alongside each beat. neg_ai is consumed inside S1.
  logic           mode1_q, mode2_q, mode3_q;
  logic [ESW-1:0] es1_q, es2_q, es3_q;
  logic [DW-1:0]  ar_s_q, aix_q, sum_q, c_q, s_q, cms_q;
  logic [DW-1:0]  m1_q, m2_q, mt_q;
  logic [DW-1:0]  p1_q, p2_q;
  logic [DW-1:0]  z1_4_q, z2_4_q;
  logic           sat1_4_q, sat2_4_q;

  logic [DW-1:0]  ar_sh, ai_sh, aix_d, sum_d, cms_d;
  logic [DW-1:0]  p1_d, p2_d;
  logic [DW:0]    post1_d, post2_d;

  // The whole pipe moves only when the output slot is free or being drained.
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;

  // S1 operand preparation: pre-shift (pre mode only), optional ai negation, sum and c-2s.
  always_comb begin
    ar_sh = ar;
    ai_sh = ai;
    if (!mode) begin
      ar_sh = $signed(ar) >>> es;
      ai_sh = $signed(ai) >>> es;
    end
    aix_d = (mode & neg_ai) ? (-ai_sh) : ai_sh;
    sum_d = aix_d + ar_sh;
    cms_d = cps2 - {sin2a[DW-2:0], 1'b0};
  end

  // S3 combine; the sign of the second term flips between pre and post twiddle.
  always_comb begin
    p1_d = m1_q + mt_q;
    p2_d = mode2_q ? (mt_q - m2_q) : (m2_q - mt_q);
  end

  // S4 post-shift applied independently to both results.
  always_comb begin
    post1_d = post_shift(p1_q, mode3_q, es3_q);
    post2_d = post_shift(p2_q, mode3_q, es3_q);
  end

  // Valid chain: reset clears every in-flight beat so nothing partial escapes.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      v4_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      v1_q        <= accept;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      v4_q        <= v3_q;
      out_valid_q <= v4_q;
    end
  end

  // Datapath stages S1..S4; contents only matter when the matching valid is set.
  always_ff @(posedge clk) begin
    if (en) begin
      mode1_q  <= mode;
      es1_q    <= es;
      ar_s_q   <= ar_sh;
      aix_q    <= aix_d;
      sum_q    <= sum_d;
      c_q      <= cps2;
      s_q      <= sin2a;
      cms_q    <= cms_d;

      mode2_q  <= mode1_q;
      es2_q    <= es1_q;
      m1_q     <= mul_hi(ar_s_q, cms_q);
      m2_q     <= mul_hi(aix_q, c_q);
      mt_q     <= mul_hi(sum_q, s_q);

      mode3_q  <= mode2_q;
      es3_q    <= es2_q;
      p1_q     <= p1_d;
      p2_q     <= p2_d;

      z1_4_q   <= post1_d[DW-1:0];
      sat1_4_q <= post1_d[DW];
      z2_4_q   <= post2_d[DW-1:0];
      sat2_4_q <= post2_d[DW];
    end
  end

  // Output holding register: keeps the beat stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      z1_q     <= '0;
      z2_q     <= '0;
      sat_z1_q <= 1'b0;
      sat_z2_q <= 1'b0;
    end else if (en) begin
      z1_q     <= z1_4_q;
      z2_q     <= z2_4_q;
      sat_z1_q <= sat1_4_q;
      sat_z2_q <= sat2_4_q;
    end
  end

  // Saturated-beat counter: counts handshakes, sticks at all-ones, clear has priority.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_cnt_q <= '0;
    end else if (out_valid_q && out_ready && (sat_z1_q || sat_z2_q) && !(&sat_cnt_q)) begin
      sat_cnt_q <= sat_cnt_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign z1        = z1_q;
  assign z2        = z2_q;
  assign sat_z1    = sat_z1_q;
  assign sat_z2    = sat_z2_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_imdct_rot_pipe.sv
// Scoreboard bench for imdct_rot_pipe: expected beats are queued on acceptance
// and compared in order when the output handshakes.
module tb_imdct_rot_pipe;
  localparam int DW   = 32;
  localparam int MSH  = 32;
  localparam int ESW  = 5;
  localparam int CNTW = 3;
  localparam int CNT_MAX = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            mode = 1'b0;
  logic            neg_ai = 1'b0;
  logic [ESW-1:0]  es = '0;
  logic [DW-1:0]   ar = '0, ai = '0, cps2 = '0, sin2a = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   z1, z2;
  logic            sat_z1, sat_z2;
  logic [CNTW-1:0] sat_cnt;
  logic            sat_clr = 1'b0;

  imdct_rot_pipe #(.DW(DW), .MSH(MSH), .ESW(ESW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .neg_ai(neg_ai), .es(es), .ar(ar), .ai(ai),
    .cps2(cps2), .sin2a(sin2a), .out_valid(out_valid), .out_ready(out_ready),
    .z1(z1), .z2(z2), .sat_z1(sat_z1), .sat_z2(sat_z2),
    .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z1;
    logic [31:0] z2;
    logic        s1;
    logic        s2;
    bit          chk_lat;
    int          acc_edge;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   beat_no = 0;
  int   cnt_model = 0;
  bit   mon_on = 0;
  bit   lat_flag = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic longint wrap32(input longint x);
    logic [31:0] t;
    t = x[31:0];
    return longint'($signed(t));
  endfunction

  function automatic longint mulm(input longint a, input longint b);
    return wrap32((a * b) >>> 32);
  endfunction

  // Post shift: a value fits after shifting by e iff it lies in [-2^(30-e), 2^(30-e)).
  function automatic void postm(input longint p, input bit m, input int e,
                                output logic [31:0] z, output logic s);
    int     ee;
    longint lim;
    ee = (e > 30) ? 30 : e;
    lim = longint'(1) <<< (30 - ee);
    s = 1'b0;
    if (!m) z = 32'(p);
    else if (p >= -lim && p < lim) z = 32'(p <<< ee);
    else begin
      s = 1'b1;
      z = (p >= 0) ? 32'h3FFF_FFFF : 32'hC000_0000;
    end
  endfunction

  function automatic exp_t model(input bit m, input bit n, input int e,
                                 input logic [31:0] ar_v, input logic [31:0] ai_v,
                                 input logic [31:0] c_v, input logic [31:0] s_v);
    exp_t   r;
    longint a_r, a_i, c, s, ax, sm, cms, m1, m2, mt, p1, p2;
    a_r = longint'($signed(ar_v));
    a_i = longint'($signed(ai_v));
    c   = longint'($signed(c_v));
    s   = longint'($signed(s_v));
    if (!m) begin
      a_r = a_r >>> e;
      a_i = a_i >>> e;
    end
    ax  = (m && n) ? wrap32(-a_i) : a_i;
    sm  = wrap32(ax + a_r);
    cms = wrap32(c - 2 * s);
    m1  = mulm(a_r, cms);
    m2  = mulm(ax, c);
    mt  = mulm(sm, s);
    p1  = wrap32(m1 + mt);
    p2  = wrap32(m ? (mt - m2) : (m2 - mt));
    postm(p1, m, e, r.z1, r.s1);
    postm(p2, m, e, r.z2, r.s2);
    r.chk_lat = 1'b0;
    r.acc_edge = 0;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: inputs and outputs are stable until the next rising edge.
  always @(negedge clk) begin
    exp_t e, g;
    if (mon_on) begin
      check_val("sat_cnt", 64'(sat_cnt), 64'(cnt_model));
      if (rst) begin
        sb_q.delete();
        cnt_model = 0;
      end else begin
        if (in_valid && in_ready) begin
          e = model(mode, neg_ai, int'(es), ar, ai, cps2, sin2a);
          e.chk_lat = lat_flag;
          e.acc_edge = cyc + 1;
          sb_q.push_back(e);
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check_val("unexp_out", 64'(out_valid), 64'(0));
          end else begin
            g = sb_q.pop_front();
            $display("beat %0d z1=%h z2=%h sat=%b%b cnt=%0d", beat_no, z1, z2, sat_z1, sat_z2, sat_cnt);
            beat_no++;
            check_val("z1", 64'(z1), 64'(g.z1));
            check_val("z2", 64'(z2), 64'(g.z2));
            check_val("sat_z1", 64'(sat_z1), 64'(g.s1));
            check_val("sat_z2", 64'(sat_z2), 64'(g.s2));
            if (g.chk_lat) check_val("latency", 64'(cyc), 64'(g.acc_edge + 4));
            if ((g.s1 || g.s2) && cnt_model < CNT_MAX) cnt_model++;
          end
        end
        if (sat_clr) cnt_model = 0;
      end
    end
  end

  // Present one beat (called just after a rising edge) and hold it until accepted.
  task automatic send(input bit m, input bit n, input int e, input logic [31:0] a_r,
                      input logic [31:0] a_i, input logic [31:0] c, input logic [31:0] s);
    bit done;
    done = 0;
    in_valid = 1'b1;
    mode = m; neg_ai = n; es = ESW'(e);
    ar = a_r; ai = a_i; cps2 = c; sin2a = s;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) check_val("send_timeout", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    check_val("drain", 64'(sb_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic send_rand();
    send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
         $urandom, $urandom, $urandom, $urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_on = 1;
    @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_in_ready", 64'(in_ready), 64'(1));
    check_val("rst_z1", 64'(z1), 64'(0));
    check_val("rst_z2", 64'(z2), 64'(0));
    check_val("rst_sat", 64'({sat_z1, sat_z2}), 64'(0));
    @(posedge clk); #1;

    // Directed beats: pre mode with latency check, post-mode shift and saturation, ai negation.
    lat_flag = 1;
    send(0, 0, 0, 32'h4000_0000, 32'h0, 32'h4000_0000, 32'h0);
    lat_flag = 0;
    drain();
    send(1, 0, 1, 32'h4000_0000, 32'h0, 32'h4000_0000, 32'h0);
    send(1, 0, 2, 32'h4000_0000, 32'h0, 32'h4000_0000, 32'h0);
    drain();
    check_val("cnt_one_sat", 64'(sat_cnt), 64'(1));
    send(1, 1, 0, 32'h0, 32'h4000_0000, 32'h4000_0000, 32'h0);
    send(1, 0, 3, 32'hC000_0000, 32'h0, 32'h4000_0000, 32'h0);
    send(0, 0, 31, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678);
    send(1, 0, 31, 32'h0000_0100, 32'h0, 32'h4000_0000, 32'h0);
    drain();

    // Eight back-to-back beats with a three-cycle downstream stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_val("stall_in_ready", 64'(in_ready), 64'(0));
          check_val("stall_out_valid", 64'(out_valid), 64'(1));
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight: none of them may ever appear.
    send_rand(); send_rand(); send_rand();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_val("midrst_out_valid", 64'(out_valid), 64'(0));
    check_val("midrst_sat_cnt", 64'(sat_cnt), 64'(0));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_val("post_rst_idle", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;

    // Clear coinciding with a saturating handshake.
    send(1, 0, 2, 32'h4000_0000, 32'h0, 32'h4000_0000, 32'h0);
    drain();
    check_val("cnt_before_clr", 64'(sat_cnt), 64'(1));
    out_ready = 1'b0;
    send(1, 0, 2, 32'h4000_0000, 32'h0, 32'h4000_0000, 32'h0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check_val("held_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    sat_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    @(negedge clk);
    check_val("clr_wins", 64'(sat_cnt), 64'(0));
    @(posedge clk); #1;

    // Drive the counter past all-ones; it must stick.
    for (int i = 0; i < 9; i++)
      send(1, 0, 2, 32'h4000_0000, 32'h0, 32'h4000_0000, 32'h0);
    drain();
    check_val("cnt_sticky", 64'(sat_cnt), 64'(CNT_MAX));

    check_val("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
